// File: rtl/div_pkg.sv
// div_pkg: shared op/state encodings and defaults for the divide unit
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 32
`endif
package div_pkg;
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  localparam int DEF_LATENCY = 4;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/divider.sv
// divider: combinational divide; signed mode negates both results when operand signs differ
module divider #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sign,
  output logic [N-1:0] quot,
  output logic [N-1:0] rem
);
  logic neg_a, neg_b;
  logic [N-1:0] ua, ub, q, r;
  always_comb begin
    neg_a = sign & a[N-1];
    neg_b = sign & b[N-1];
    ua = neg_a ? -a : a;
    ub = neg_b ? -b : b;
    q = (ub == '0) ? '1 : ua / ub;
    r = (ub == '0) ? ua : ua % ub;
    quot = (neg_a ^ neg_b) ? -q : q;
    rem = (neg_a ^ neg_b) ? -r : r;
  end
endmodule

// File: rtl/div_unit.sv
// div_unit: multicycle divide/remainder unit between issue and writeback handshakes
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 32
`endif
module div_unit import div_pkg::*; #(
  parameter int N = `DEFAULT_WIDTH,
  parameter int LATENCY = DEF_LATENCY,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dbz
);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [N-1:0] a, b, quot, rem;
  logic [1:0] op;
  logic accept;
  // operands stay frozen in BUSY, so the divider is a LATENCY-cycle multicycle path
  divider #(.N(N)) u_div (.a(a), .b(b), .sign(~op[0]), .quot(quot), .rem(rem));
  assign in_ready = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept = in_valid & in_ready & ~flush;
  always_comb begin
    nxt = flush ? IDLE :
          (state == IDLE) ? (in_valid ? ((in_b == '0) ? DONE : BUSY) : IDLE) :
          (state == BUSY) ? ((cnt == '0) ? DONE : BUSY) :
          (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0;
      b <= '0;
      op <= '0;
      cnt <= '0;
      out_result <= '0;
      out_tag <= '0;
      out_dbz <= 1'b0;
    end else if (accept) begin
      a <= in_a;
      b <= in_b;
      op <= in_op;
      out_tag <= in_tag;
      cnt <= CW'(LATENCY - 1);
      if (in_b == '0) begin
        out_result <= in_op[1] ? in_a : '1;
        out_dbz <= 1'b1;
      end
    end else if (state == BUSY && !flush) begin
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        out_result <= op[1] ? rem : quot;
        out_dbz <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors plus a cycle-level reference model checked every cycle
module tb_div_unit;
  import div_pkg::*;
  localparam int LAT = 4;
  logic clk = 0, rst_n = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_a = 0, in_b = 0;
  logic [1:0] in_op = 0;
  logic [4:0] in_tag = 0;
  logic in_ready, out_valid, out_dbz;
  logic [31:0] out_result;
  logic [4:0] out_tag;
  int total = 0, bad = 0;
  logic m_pend = 0, m_valid = 0, m_dbz = 0;
  logic [31:0] m_res = 0;
  logic [4:0] m_tag = 0;
  int m_wait = 0;

  div_unit #(.N(32), .LATENCY(LAT), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag), .out_dbz(out_dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r, mr;
    if (b == 0) return {1'b1, op[1] ? a : 32'hFFFF_FFFF};
    if (!op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      mr = (sa < 0 ? -sa : sa) % (sb < 0 ? -sb : sb);
      r = ((sa < 0) != (sb < 0)) ? -mr : mr;
    end else begin
      sa = longint'(a);
      sb = longint'(b);
      q = sa / sb;
      r = sa % sb;
    end
    return {1'b0, op[1] ? r[31:0] : q[31:0]};
  endfunction

  // reference: result appears 1 cycle after accept for b==0, LAT+1 cycles otherwise
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 0;
      m_valid <= 0;
    end else if (flush) begin
      m_pend <= 0;
      m_valid <= 0;
    end else if (m_valid) begin
      if (out_ready) m_valid <= 0;
    end else if (m_pend) begin
      if (m_wait == 0) begin
        m_pend <= 0;
        m_valid <= 1;
      end else m_wait <= m_wait - 1;
    end else if (in_valid) begin
      {m_dbz, m_res} <= model(in_op, in_a, in_b);
      m_tag <= in_tag;
      if (in_b == 0) m_valid <= 1;
      else begin
        m_pend <= 1;
        m_wait <= LAT - 1;
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready", in_ready, !(m_pend || m_valid));
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("out_result", out_result, m_res);
      check("out_tag", out_tag, m_tag);
      check("out_dbz", out_dbz, m_dbz);
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    @(posedge clk); #1;
    in_valid = 1; in_a = a; in_b = b; in_op = op; in_tag = tag; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) check("timeout", out_valid, 1);
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp, input logic exp_dbz, input int exp_lat);
    int n;
    issue(op, a, b, tag);
    wait_valid(n);
    check({nm, "_lat"}, n, exp_lat);
    check({nm, "_res"}, out_result, exp);
    check({nm, "_tag"}, out_tag, tag);
    check({nm, "_dbz"}, out_dbz, exp_dbz);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  initial begin
    int n;
    #2 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_result", out_result, 0);
    check("rst_tag", out_tag, 0);
    check("rst_dbz", out_dbz, 0);
    check("rst_ready", in_ready, 1);
    rst_n = 1;
    run_op("divu", OP_DIVU, 100, 7, 3, 14, 0, LAT + 1);
    run_op("remu", OP_REMU, 100, 7, 3, 2, 0, LAT + 1);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 2, 5, 32'hFFFF_FFFD, 0, LAT + 1);
    run_op("rem_neg", OP_REM, 32'hFFFF_FFF9, 2, 6, 32'hFFFF_FFFF, 0, LAT + 1);
    run_op("div_nn", OP_DIV, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 7, 4, 0, LAT + 1);
    run_op("divu_dbz", OP_DIVU, 32'h1234, 0, 8, 32'hFFFF_FFFF, 1, 1);
    run_op("rem_dbz", OP_REM, 32'h1234, 0, 9, 32'h1234, 1, 1);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h8000_0000, 0, LAT + 1);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 11, 0, 0, LAT + 1);
    // backpressure: result must hold while writeback stalls
    issue(OP_DIVU, 100, 7, 12);
    wait_valid(n);
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1);
      check("bp_result", out_result, 14);
      check("bp_tag", out_tag, 12);
      check("bp_ready", in_ready, 0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check("bp_release", in_ready, 1);
    // flush in BUSY cycle 2 with a competing divide-by-zero offer
    issue(OP_DIV, 100, 7, 13);
    @(posedge clk); #1;
    flush = 1; in_valid = 1; in_b = 0;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    check("fl_ready", in_ready, 1);
    repeat (8) begin
      @(posedge clk); #1;
      check("fl_novalid", out_valid, 0);
    end
    // flush in IDLE blocks the offered op
    flush = 1; in_valid = 1; in_b = 5;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    check("fl_idle_ready", in_ready, 1);
    check("fl_idle_valid", out_valid, 0);
    // async reset mid-BUSY clears stale result of 14 immediately
    issue(OP_DIVU, 50, 3, 14);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_result", out_result, 0);
    check("ar_tag", out_tag, 0);
    check("ar_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1;
    run_op("post_rst", OP_DIVU, 50, 3, 15, 16, 0, LAT + 1);
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multicycle divide execution unit sitting between the decode/issue stage and writeback.
- Accepts one divide/remainder operation through a valid/ready handshake and registers its operands.
- Holds the operands stable for LATENCY cycles while the combinational `divider` settles, treated as a multicycle path.
- Resolves divide-by-zero directly, then presents a tagged result to writeback through a second valid/ready handshake.

Parameters:
- N, `DEFAULT_WIDTH: operand and result width.
- LATENCY, 4: cycles operands are held before the divider output is sampled; must be >= 1.
- TAG_W, 5: width of the destination tag carried alongside the operation.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- flush  input  1  synchronous pipeline flush; aborts any operation.
- in_valid  input  1  operation offered.
- in_ready  output  1  unit can accept an operation (IDLE only).
- in_a  input  N  dividend.
- in_b  input  N  divisor.
- in_op  input  2  00 DIV signed quotient, 01 DIVU, 10 REM signed, 11 REMU.
- in_tag  input  TAG_W  destination tag.
- out_valid  output  1  result available.
- out_ready  input  1  writeback accepts the result.
- out_result  output  N  quotient or remainder, selected by op.
- out_tag  output  TAG_W  tag of the result.
- out_dbz  output  1  divisor was zero.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - state = IDLE.
  - out_valid = 0, out_result = 0, out_tag = 0, out_dbz = 0.
  - Counter = 0, operand registers = 0.
- in_ready = (state == IDLE); it is combinational from state only.
- State IDLE:
  - An accept occurs when in_valid & in_ready at an edge (cycle k).
  - On accept, latch a, b, op and tag.
  - If b == 0: go to DONE. out_valid appears in cycle k+1.
  - Otherwise: go to BUSY with counter = LATENCY-1.
- State BUSY:
  - Operand registers are frozen.
  - `divider` sign input = ~op[0].
  - Counter decrements by 1 per cycle.
  - At the edge where counter == 0, register quot (op[1]=0) or rem (op[1]=1) into out_result, set out_dbz = 0 and go to DONE.
  - out_valid first appears in cycle k+LATENCY+1.
- State DONE:
  - out_valid = 1; out_result, out_tag and out_dbz are stable until the handshake.
  - On out_valid & out_ready, go to IDLE.
  - No new accept occurs in the same cycle, so peak throughput is one operation per LATENCY+2 cycles.
- Divide-by-zero result:
  - Quotient ops return all ones.
  - Remainder ops return a unchanged.
  - out_dbz = 1.
- Signed overflow (a = 2^(N-1), b = all ones, signed):
  - Quotient = 2^(N-1), remainder = 0.
  - The `divider` produces this naturally; the bench must confirm it.
- Sign convention:
  - Signed results come unmodified from `divider`.
  - Both quotient and remainder are negated when the operand signs differ.
- flush:
  - Highest priority over everything except reset.
  - In any state, the next state is IDLE and out_valid = 0 next cycle.
  - An in_valid in the flush cycle is not accepted.
  - out_result and out_tag keep their stale values.
- Reset mid-operation: outputs return to reset values immediately (asynchronous); the operation is lost.
- Inputs are ignored while rst_n is low.
- Inputs are don't-care outside an accept.

Decomposition:
- Package div_pkg:
  - Op encodings: OP_DIV, OP_DIVU, OP_REM, OP_REMU.
  - State encoding: IDLE, BUSY, DONE.
  - Default LATENCY.
- Width comes from `DEFAULT_WIDTH in defines.
- One sub-module: the existing `divider`, instantiated once on the registered operands.
- The controller, counter and result register stay in div_unit.

Test Plan:
- Latency and op select (N=32, LATENCY=4): in_a=100, in_b=7, op=DIVU, tag=3 accepted at cycle 0.
  - out_valid rises in cycle 5 with out_result=14, out_tag=3, out_dbz=0.
  - With op=REMU the same operands give out_result=2.
- Signed: a=-7 (0xFFFFFFF9), b=2.
  - DIV gives 0xFFFFFFFD (-3); REM gives 0xFFFFFFFF (-1).
  - a=-8, b=-2, DIV gives 4.
- Divide by zero: a=0x1234, b=0.
  - DIVU: out_valid in cycle 1, out_result=0xFFFFFFFF, out_dbz=1.
  - REM: out_result=0x1234, out_dbz=1.
- Overflow: a=0x80000000, b=0xFFFFFFFF, DIV gives 0x80000000; REM gives 0.
- Backpressure: out_ready held 0 for 10 cycles.
  - out_valid, out_result and out_tag stay stable; in_ready stays 0 throughout.
  - Release out_ready: in_ready=1 the next cycle.
- Flush and reset:
  - flush in BUSY cycle 2 gives out_valid never asserted and in_ready=1 next cycle.
  - rst_n pulsed low mid-BUSY forces outputs to 0 asynchronously; a subsequent op completes correctly.
